// File: rtl/ahbl_to_axi_pkg.sv
// Shared encodings, FSM state type and address-phase helpers for the
// AHB-Lite to AXI bridge.
package ahbl_to_axi_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_DATA,
      ST_ERR1,
      ST_ERR2
   } state_e;

   // Byte lanes of the 64-bit AXI data bus touched by an AHB transfer.
   function automatic logic [7:0] wstrb_f(input logic [2:0] size, input logic [2:0] addr);
      logic [7:0] strb;
      case (size)
         3'd0:    strb = 8'h01 << addr;
         3'd1:    strb = 8'h03 << {addr[2:1], 1'b0};
         3'd2:    strb = 8'h0F << {addr[2], 2'b00};
         default: strb = 8'h00;
      endcase
      return strb;
   endfunction

   function automatic logic bad_xfer_f(input logic [2:0] size, input logic [1:0] addr);
      return (size > 3'd2) || ((size == 3'd1) && addr[0]) || ((size == 3'd2) && (addr != 2'b00));
   endfunction

endpackage

// File: rtl/ahbl_to_axi_bridge.sv
// AHB-Lite slave to AXI master bridge: one single-beat AXI transaction per AHB
// transfer, non-posted writes, two-cycle AHB ERROR on misalignment or AXI error.
module ahbl_to_axi_bridge
   import ahbl_to_axi_pkg::*;
#(
   parameter int ID_WIDTH = 5,
   parameter int AXI_ID   = 0
) (
   input  logic                HCLK,
   input  logic                HRESET,
   input  logic                HSEL,
   input  logic [31:0]         HADDR,
   input  logic [1:0]          HTRANS,
   input  logic                HWRITE,
   input  logic [2:0]          HSIZE,
   input  logic [2:0]          HBURST,
   input  logic [31:0]         HWDATA,
   input  logic                HREADY,
   output logic                HREADYOUT,
   output logic                HRESP,
   output logic [31:0]         HRDATA,
   output logic [ID_WIDTH-1:0] AWID,
   output logic [31:0]         AWADDR,
   output logic [3:0]          AWLEN,
   output logic [2:0]          AWSIZE,
   output logic [1:0]          AWBURST,
   output logic                AWVALID,
   input  logic                AWREADY,
   output logic [63:0]         WDATA,
   output logic [7:0]          WSTRB,
   output logic                WLAST,
   output logic                WVALID,
   input  logic                WREADY,
   input  logic [ID_WIDTH-1:0] BID,
   input  logic [1:0]          BRESP,
   input  logic                BVALID,
   output logic                BREADY,
   output logic [ID_WIDTH-1:0] ARID,
   output logic [31:0]         ARADDR,
   output logic [3:0]          ARLEN,
   output logic [2:0]          ARSIZE,
   output logic [1:0]          ARBURST,
   output logic                ARVALID,
   input  logic                ARREADY,
   input  logic [ID_WIDTH-1:0] RID,
   input  logic [63:0]         RDATA,
   input  logic [1:0]          RRESP,
   input  logic                RLAST,
   input  logic                RVALID,
   output logic                RREADY,
   output state_e              dbg_state_o
);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  size_q, size_d;
   logic [7:0]  strb_q, strb_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] hrdata_q, hrdata_d;
   logic        aw_valid_q, aw_valid_d;
   logic        w_valid_q, w_valid_d;
   logic        ar_valid_q, ar_valid_d;
   logic        wr_first_q, wr_first_d;
   logic        sample;
   logic        unused_inputs;

   assign sample        = HSEL & HREADY & HTRANS[1];
   assign unused_inputs = ^{HBURST, BID, RID, RLAST, HTRANS[0], BRESP[0], RRESP[0]};

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      size_d     = size_q;
      strb_d     = strb_q;
      wdata_d    = wdata_q;
      hrdata_d   = hrdata_q;
      aw_valid_d = aw_valid_q;
      w_valid_d  = w_valid_q;
      ar_valid_d = ar_valid_q;
      wr_first_d = wr_first_q;
      case (state_q)
         ST_IDLE, ST_ERR2: begin
            state_d = ST_IDLE;
            if (sample) begin
               addr_d = HADDR;
               size_d = HSIZE;
               strb_d = wstrb_f(HSIZE, HADDR[2:0]);
               if (bad_xfer_f(HSIZE, HADDR[1:0])) begin
                  state_d = ST_ERR1;
               end else if (HWRITE) begin
                  state_d    = ST_WR_REQ;
                  wr_first_d = 1'b1;
               end else begin
                  state_d    = ST_RD_REQ;
                  ar_valid_d = 1'b1;
               end
            end
         end
         ST_WR_REQ: begin
            // First cycle is the AHB data phase: capture HWDATA and arm both channels.
            if (wr_first_q) begin
               wdata_d    = HWDATA;
               aw_valid_d = 1'b1;
               w_valid_d  = 1'b1;
               wr_first_d = 1'b0;
            end else begin
               aw_valid_d = aw_valid_q & ~AWREADY;
               w_valid_d  = w_valid_q & ~WREADY;
               if (!aw_valid_d && !w_valid_d) state_d = ST_WR_RESP;
            end
         end
         ST_WR_RESP: begin
            if (BVALID) state_d = BRESP[1] ? ST_ERR1 : ST_IDLE;
         end
         ST_RD_REQ: begin
            if (ARREADY) begin
               ar_valid_d = 1'b0;
               state_d    = ST_RD_DATA;
            end
         end
         ST_RD_DATA: begin
            if (RVALID) begin
               hrdata_d = addr_q[2] ? RDATA[63:32] : RDATA[31:0];
               state_d  = RRESP[1] ? ST_ERR1 : ST_IDLE;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         size_q     <= '0;
         strb_q     <= '0;
         wdata_q    <= '0;
         hrdata_q   <= '0;
         aw_valid_q <= 1'b0;
         w_valid_q  <= 1'b0;
         ar_valid_q <= 1'b0;
         wr_first_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         strb_q     <= strb_d;
         wdata_q    <= wdata_d;
         hrdata_q   <= hrdata_d;
         aw_valid_q <= aw_valid_d;
         w_valid_q  <= w_valid_d;
         ar_valid_q <= ar_valid_d;
         wr_first_q <= wr_first_d;
      end
   end

   // AXI channels: a VALID once raised holds with stable payload until the
   // cycle its READY is seen high; READY outputs are pure functions of state.
   assign HREADYOUT   = (state_q == ST_IDLE) || (state_q == ST_ERR2);
   assign HRESP       = (state_q == ST_ERR1) || (state_q == ST_ERR2);
   assign HRDATA      = hrdata_q;
   assign AWID        = ID_WIDTH'(AXI_ID);
   assign AWADDR      = addr_q;
   assign AWLEN       = 4'd0;
   assign AWSIZE      = size_q;
   assign AWBURST     = AXI_BURST_INCR;
   assign AWVALID     = aw_valid_q;
   assign WDATA       = {wdata_q, wdata_q};
   assign WSTRB       = strb_q;
   assign WLAST       = 1'b1;
   assign WVALID      = w_valid_q;
   assign BREADY      = (state_q == ST_WR_RESP);
   assign ARID        = ID_WIDTH'(AXI_ID);
   assign ARADDR      = addr_q;
   assign ARLEN       = 4'd0;
   assign ARSIZE      = size_q;
   assign ARBURST     = AXI_BURST_INCR;
   assign ARVALID     = ar_valid_q;
   assign RREADY      = (state_q == ST_RD_DATA);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahbl_to_axi_bridge.sv
// Directed bench for ahbl_to_axi_bridge: AHB driver tasks, AXI responder
// tasks and an address scoreboard fed from the AXI handshakes.
module tb_ahbl_to_axi_bridge;
   import ahbl_to_axi_pkg::*;

   localparam int IDW = 5;

   logic            HCLK, HRESET;
   logic            HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
   logic [31:0]     HADDR, HWDATA, HRDATA;
   logic [1:0]      HTRANS;
   logic [2:0]      HSIZE, HBURST;
   logic [IDW-1:0]  AWID, BID, ARID, RID;
   logic [31:0]     AWADDR, ARADDR;
   logic [3:0]      AWLEN, ARLEN;
   logic [2:0]      AWSIZE, ARSIZE;
   logic [1:0]      AWBURST, ARBURST, BRESP, RRESP;
   logic            AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic            ARVALID, ARREADY, RLAST, RVALID, RREADY;
   logic [63:0]     WDATA, RDATA;
   logic [7:0]      WSTRB;
   state_e          dbg_state;

   int              n_vec = 0;
   int              n_miss = 0;
   logic [63:0]     exp_q[$];
   logic [63:0]     exp_v;
   int              awv_cyc, wv_cyc, arv_cyc, aw_cnt, w_cnt, ar_cnt;
   logic [63:0]     last_wdata;
   logic [7:0]      last_wstrb;
   logic            last_wlast;
   logic [3:0]      last_awlen, last_arlen;
   logic [2:0]      last_awsize, last_arsize;
   logic [1:0]      last_awburst, last_arburst;
   logic [IDW-1:0]  last_awid, last_arid;
   int              waits;
   logic            resp_wait, resp_done;

   ahbl_to_axi_bridge #(.ID_WIDTH(IDW), .AXI_ID(3)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .dbg_state_o(dbg_state)
   );

   // Single-slave interconnect: the bus ready is this slave's ready.
   assign HREADY = HREADYOUT;

   // ---------------- clock / reset ----------------
   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // AXI handshake monitor: scoreboard on addresses, captures payload fields.
   always @(negedge HCLK) begin
      if (!HRESET) begin
         if (AWVALID) awv_cyc++;
         if (WVALID)  wv_cyc++;
         if (ARVALID) arv_cyc++;
         if (AWVALID && AWREADY) begin
            aw_cnt++;
            last_awlen = AWLEN; last_awsize = AWSIZE; last_awburst = AWBURST; last_awid = AWID;
            if (exp_q.size() == 0) check_vec("aw_unexpected", 64'd1, 64'd0);
            else begin
               exp_v = exp_q.pop_front();
               check_vec("aw_addr", {31'd0, 1'b1, AWADDR}, exp_v);
            end
         end
         if (WVALID && WREADY) begin
            w_cnt++;
            last_wdata = WDATA; last_wstrb = WSTRB; last_wlast = WLAST;
         end
         if (ARVALID && ARREADY) begin
            ar_cnt++;
            last_arlen = ARLEN; last_arsize = ARSIZE; last_arburst = ARBURST; last_arid = ARID;
            if (exp_q.size() == 0) check_vec("ar_unexpected", 64'd1, 64'd0);
            else begin
               exp_v = exp_q.pop_front();
               check_vec("ar_addr", {31'd0, 1'b0, ARADDR}, exp_v);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic clr_counts();
      awv_cyc = 0; wv_cyc = 0; arv_cyc = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
   endtask

   task automatic drive_addr(input logic wr, input logic [31:0] addr, input logic [2:0] size);
      HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = wr; HADDR = addr; HSIZE = size;
   endtask

   task automatic drive_idle();
      HSEL = 1'b0; HTRANS = HTRANS_IDLE;
   endtask

   // Called one cycle after the address phase; returns in the HREADYOUT=1 cycle.
   task automatic data_phase(input logic [31:0] wdata, output int nw,
                             output logic rsp_w, output logic rsp_d);
      drive_idle();
      HWDATA = wdata;
      nw = 0;
      rsp_w = 1'b0;
      while (!HREADYOUT && nw < 100) begin
         rsp_w = HRESP;
         nw++;
         tick();
      end
      if (!HREADYOUT) check_vec("hreadyout_timeout", 64'd0, 64'd1);
      rsp_d = HRESP;
   endtask

   task automatic b_resp(input int dly, input logic [1:0] resp);
      int n;
      n = 0;
      while (!BREADY && n < 100) begin tick(); n++; end
      if (!BREADY) check_vec("bready_timeout", 64'd0, 64'd1);
      repeat (dly) tick();
      BVALID = 1'b1; BRESP = resp;
      tick();
      BVALID = 1'b0; BRESP = 2'b00;
   endtask

   task automatic r_resp(input int dly, input logic [63:0] data, input logic [1:0] resp);
      int n;
      n = 0;
      while (!RREADY && n < 100) begin tick(); n++; end
      if (!RREADY) check_vec("rready_timeout", 64'd0, 64'd1);
      repeat (dly) tick();
      RVALID = 1'b1; RDATA = data; RRESP = resp; RLAST = 1'b1;
      tick();
      RVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0;
   endtask

   task automatic aw_resp(input int hold);
      int n;
      n = 0;
      while (!AWVALID && n < 100) begin tick(); n++; end
      if (!AWVALID) check_vec("awvalid_timeout", 64'd0, 64'd1);
      repeat (hold - 1) tick();
      AWREADY = 1'b1;
      tick();
      AWREADY = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      HRESET = 1'b1;
      HSEL = 0; HADDR = 0; HTRANS = HTRANS_IDLE; HWRITE = 0; HSIZE = 0; HBURST = 0; HWDATA = 0;
      AWREADY = 1; WREADY = 1; ARREADY = 1; BVALID = 0; BRESP = 0; BID = 0;
      RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RID = 0;
      clr_counts();
      repeat (2) @(posedge HCLK);
      #1;
      check_vec("rst_hreadyout", HREADYOUT, 1);
      check_vec("rst_hresp", HRESP, 0);
      check_vec("rst_hrdata", HRDATA, 0);
      check_vec("rst_valids", {AWVALID, WVALID, ARVALID}, 0);
      check_vec("rst_readies", {BREADY, RREADY}, 0);
      check_vec("rst_state", dbg_state, ST_IDLE);
      HRESET = 1'b0;
      tick();

      // BUSY, and NONSEQ with HSEL low: zero-wait OKAY, no transfer
      HSEL = 1; HTRANS = HTRANS_BUSY; HWRITE = 1; HADDR = 32'h0000_0010; HSIZE = 2;
      tick();
      check_vec("busy_ready", {HREADYOUT, HRESP}, 2'b10);
      check_vec("busy_state", dbg_state, ST_IDLE);
      HSEL = 0; HTRANS = HTRANS_NONSEQ;
      tick();
      check_vec("nosel_ready", {HREADYOUT, HRESP}, 2'b10);
      check_vec("nosel_state", dbg_state, ST_IDLE);
      drive_idle();

      // Word write, everything ready immediately
      clr_counts();
      exp_q.push_back({31'd0, 1'b1, 32'h1000_0004});
      drive_addr(1, 32'h1000_0004, 3'd2);
      tick();
      fork
         data_phase(32'hDEAD_BEEF, waits, resp_wait, resp_done);
         b_resp(0, 2'b00);
      join
      check_vec("wr_waits", waits, 3);
      check_vec("wr_hresp", resp_done, 0);
      check_vec("wr_aw_fields", {last_awlen, last_awsize, last_awburst}, {4'd0, 3'd2, 2'b01});
      check_vec("wr_awid", last_awid, 3);
      check_vec("wr_wstrb", last_wstrb, 8'hF0);
      check_vec("wr_wdata", last_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
      check_vec("wr_wlast", last_wlast, 1);
      check_vec("wr_counts", {aw_cnt[3:0], w_cnt[3:0]}, 8'h11);

      // Halfword write at byte offset 6
      clr_counts();
      exp_q.push_back({31'd0, 1'b1, 32'h3000_0006});
      drive_addr(1, 32'h3000_0006, 3'd1);
      tick();
      fork
         data_phase(32'h1234_CAFE, waits, resp_wait, resp_done);
         b_resp(0, 2'b00);
      join
      check_vec("hw_wstrb", last_wstrb, 8'hC0);
      check_vec("hw_awsize", last_awsize, 1);
      check_vec("hw_waits", waits, 3);

      // Byte read, R after 4 wait cycles
      clr_counts();
      exp_q.push_back({31'd0, 1'b0, 32'h2000_0003});
      drive_addr(0, 32'h2000_0003, 3'd0);
      tick();
      fork
         data_phase(32'h0, waits, resp_wait, resp_done);
         r_resp(4, 64'h1122_3344_5566_7788, 2'b00);
      join
      check_vec("brd_waits", waits, 6);
      check_vec("brd_hrdata", HRDATA, 32'h5566_7788);
      check_vec("brd_hresp", resp_done, 0);
      check_vec("brd_ar_fields", {last_arlen, last_arsize, last_arburst}, {4'd0, 3'd0, 2'b01});
      check_vec("brd_arid", last_arid, 3);

      // Word read from the upper lane, immediate R
      exp_q.push_back({31'd0, 1'b0, 32'h2000_000C});
      drive_addr(0, 32'h2000_000C, 3'd2);
      tick();
      fork
         data_phase(32'h0, waits, resp_wait, resp_done);
         r_resp(0, 64'hAABB_CCDD_0102_0304, 2'b00);
      join
      check_vec("wrd_waits", waits, 2);
      check_vec("wrd_hrdata", HRDATA, 32'hAABB_CCDD);

      // Write with AWREADY after 5 cycles, SLVERR on B
      clr_counts();
      AWREADY = 1'b0;
      exp_q.push_back({31'd0, 1'b1, 32'h4000_0000});
      drive_addr(1, 32'h4000_0000, 3'd2);
      tick();
      fork
         data_phase(32'h0BAD_F00D, waits, resp_wait, resp_done);
         aw_resp(5);
         b_resp(0, 2'b10);
      join
      check_vec("slv_awvalid_cyc", awv_cyc, 5);
      check_vec("slv_wvalid_cyc", wv_cyc, 1);
      check_vec("slv_wstrb", last_wstrb, 8'h0F);
      check_vec("slv_waits", waits, 8);
      check_vec("slv_err1_hresp", resp_wait, 1);
      check_vec("slv_err2_hresp", resp_done, 1);
      check_vec("slv_hrdata_hold", HRDATA, 32'hAABB_CCDD);
      tick();
      check_vec("slv_after_idle", {HREADYOUT, HRESP}, 2'b10);
      AWREADY = 1'b1;

      // Illegal size and misaligned halfword: ERROR with no AXI activity
      clr_counts();
      drive_addr(0, 32'h5000_0000, 3'd3);
      tick();
      data_phase(32'h0, waits, resp_wait, resp_done);
      check_vec("sz3_waits", waits, 1);
      check_vec("sz3_hresp", {resp_wait, resp_done}, 2'b11);
      tick();
      drive_addr(1, 32'h5000_0001, 3'd1);
      tick();
      data_phase(32'h5555_5555, waits, resp_wait, resp_done);
      check_vec("mis_waits", waits, 1);
      check_vec("mis_hresp", {resp_wait, resp_done}, 2'b11);
      tick();
      check_vec("err_no_valid", awv_cyc + wv_cyc + arv_cyc, 0);

      // Read with SLVERR on R: data still captured, ERROR response
      exp_q.push_back({31'd0, 1'b0, 32'h6000_0000});
      drive_addr(0, 32'h6000_0000, 3'd2);
      tick();
      fork
         data_phase(32'h0, waits, resp_wait, resp_done);
         r_resp(0, 64'h9999_9999_1234_5678, 2'b10);
      join
      check_vec("rerr_waits", waits, 3);
      check_vec("rerr_hresp", {resp_wait, resp_done}, 2'b11);
      check_vec("rerr_hrdata", HRDATA, 32'h1234_5678);
      tick();

      // Back-to-back write then read
      clr_counts();
      exp_q.push_back({31'd0, 1'b1, 32'h7000_0008});
      exp_q.push_back({31'd0, 1'b0, 32'h7000_0010});
      drive_addr(1, 32'h7000_0008, 3'd2);
      tick();
      fork
         data_phase(32'hFACE_FEED, waits, resp_wait, resp_done);
         b_resp(0, 2'b00);
      join
      check_vec("b2b_wr_waits", waits, 3);
      drive_addr(0, 32'h7000_0010, 3'd2);
      tick();
      check_vec("b2b_arvalid", ARVALID, 1);
      fork
         data_phase(32'h0, waits, resp_wait, resp_done);
         r_resp(0, 64'h1357_9BDF_2468_ACE0, 2'b00);
      join
      check_vec("b2b_rd_waits", waits, 2);
      check_vec("b2b_hrdata", HRDATA, 32'h2468_ACE0);
      check_vec("b2b_wstrb", last_wstrb, 8'h0F);
      check_vec("b2b_counts", {aw_cnt[3:0], ar_cnt[3:0]}, 8'h11);

      // Reset pulse while ARVALID is high
      ARREADY = 1'b0;
      drive_addr(0, 32'h8000_0000, 3'd2);
      tick();
      check_vec("rst_mid_arvalid_pre", ARVALID, 1);
      drive_idle();
      #2 HRESET = 1'b1;
      #1;
      check_vec("rst_mid_arvalid", ARVALID, 0);
      check_vec("rst_mid_ready", {HREADYOUT, HRESP}, 2'b10);
      check_vec("rst_mid_state", dbg_state, ST_IDLE);
      check_vec("rst_mid_hrdata", HRDATA, 0);
      #2 HRESET = 1'b0;
      ARREADY = 1'b1;
      tick();
      tick();
      check_vec("post_rst_state", dbg_state, ST_IDLE);
      check_vec("post_rst_valids", {AWVALID, WVALID, ARVALID}, 0);

      check_vec("exp_q_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ahbl_to_axi_bridge.md
AHBL_TO_AXI_BRIDGE -- requirements
Module: ahbl_to_axi_bridge

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 5: width of AWID/BID/ARID/RID.
REQ-002 SHALL have parameter AXI_ID, default 0: constant ID driven on AWID and ARID.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, with these ports first: HCLK in 1, clock for all logic; HRESET in 1, asynchronous active-high reset.
REQ-004 SHALL have these AHB-Lite slave ports:
- HSEL in 1; HADDR in 32; HTRANS in 2; HWRITE in 1; HSIZE in 3.
- HBURST in 3, ignored.
- HWDATA in 32; HREADY in 1, bus ready.
- HREADYOUT out 1; HRESP out 1; HRDATA out 32.
REQ-005 SHALL have these AXI write master ports: AWID out ID_WIDTH; AWADDR out 32; AWLEN out 4; AWSIZE out 3; AWBURST out 2; AWVALID out 1; AWREADY in 1; WDATA out 64; WSTRB out 8; WLAST out 1; WVALID out 1; WREADY in 1; BID in ID_WIDTH; BRESP in 2; BVALID in 1; BREADY out 1.
REQ-006 SHALL have these AXI read master ports: ARID out ID_WIDTH; ARADDR out 32; ARLEN out 4; ARSIZE out 3; ARBURST out 2; ARVALID out 1; ARREADY in 1; RID in ID_WIDTH; RDATA in 64; RRESP in 2; RLAST in 1; RVALID in 1; RREADY out 1.

Function
REQ-007 SHALL sample the address phase only when HSEL & HREADY & HTRANS[1]=1 (NONSEQ/SEQ); IDLE/BUSY or HSEL=0 SHALL give a zero-wait OKAY.
REQ-008 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, ERR1, ERR2.
REQ-009 SHALL take these transitions from IDLE on a sampled transfer:
- HSIZE>2, or HADDR not aligned to HSIZE: to ERR1, with no AXI access.
- Otherwise write: to WR_REQ.
- Otherwise read: to RD_REQ.
REQ-010 In WR_REQ, SHALL register HWDATA in the first cycle and assert AWVALID and WVALID together in that cycle.
REQ-011 SHALL drop AWVALID and WVALID independently, each on its own handshake, and SHALL go to WR_RESP once both handshakes have completed (same or different cycles).
REQ-012 SHALL drive AXI write fields as follows: AWADDR=captured HADDR, AWSIZE=HSIZE, AWLEN=0, AWBURST=2'b01, WLAST=1, WDATA={HWDATA,HWDATA}.
REQ-013 SHALL drive WSTRB as follows:
- Byte: 8'h01<<HADDR[2:0].
- Half: 8'h03<<{HADDR[2:1],1'b0}.
- Word: 8'h0F<<{HADDR[2],2'b00}.
REQ-014 In WR_RESP, SHALL hold BREADY=1; on BVALID, SHALL go to IDLE with OKAY if BRESP[1]=0, else to ERR1. Writes are non-posted.
REQ-015 In RD_REQ, SHALL assert ARVALID with the same field rules as REQ-012 and SHALL go to RD_DATA on ARREADY.
REQ-016 In RD_DATA, SHALL hold RREADY=1; on RVALID, SHALL register HRDATA=HADDR[2] ? RDATA[63:32] : RDATA[31:0].
REQ-017 On RVALID in RD_DATA, SHALL go to IDLE if RRESP[1]=0, else to ERR1.
REQ-018 SHALL hold HREADYOUT=0 throughout WR_REQ, WR_RESP, RD_REQ, RD_DATA and ERR1.
REQ-019 Latency: SHALL raise HREADYOUT in the cycle after the B or R handshake; minimum 3 wait states for a write and 2 for a read when AXI responds immediately.
REQ-020 SHALL produce the error response as two cycles: ERR1 (HRESP=1, HREADYOUT=0), then ERR2 (HRESP=1, HREADYOUT=1), then IDLE.
REQ-021 SHALL accept a new address phase in the same cycle that HREADYOUT=1 completes the previous transfer (IDLE or ERR2), so back-to-back transfers are supported.
REQ-022 SHALL ignore BID, RID and RLAST; at most one AXI transaction is outstanding.
REQ-023 SHALL hold HRDATA stable until the next read completes.

Reset
REQ-024 While HRESET=1, SHALL force: state=IDLE; HREADYOUT=1; HRESP=0; HRDATA=0; all VALID/READY outputs=0; address, data and strobe registers=0.
REQ-025 Reset asserted mid-transaction SHALL abort immediately with no further AXI handshakes; the system resets both sides.

Structure
REQ-026 Package ahbl_to_axi_pkg SHALL hold the following; there is a single module with no sub-module:
- HTRANS encodings.
- AXI BURST/RESP encodings.
- The FSM state enum.
- The strobe-generation function.

Verification
REQ-027 Word write 0x1000_0004=0xDEADBEEF with AW/W/B ready immediately -> one AW with AWADDR=0x1000_0004, AWLEN=0, AWSIZE=2; WSTRB=0xF0; WDATA[63:32]=0xDEADBEEF; HREADYOUT low 3 cycles; HRESP=0.
REQ-028 Byte read 0x2000_0003 with RDATA=0x1122334455667788 after 4 wait cycles -> ARSIZE=0, HRDATA=0x55667788, HREADYOUT=1 in the cycle after the R handshake.
REQ-029 Write with AWREADY delayed 5 cycles and WREADY immediate, then BRESP=2'b10 -> WVALID drops after 1 cycle, AWVALID held 5 cycles, then two-cycle ERROR (HREADYOUT 0 then 1, HRESP=1).
REQ-030 HSIZE=3, or halfword at 0x...1 -> no AXI VALID asserted, two-cycle ERROR response.
REQ-031 Back-to-back write then read, second NONSEQ presented during the final HREADYOUT=1 cycle -> ARVALID in the following cycle, no lost transfer.
REQ-032 HRESET pulsed while ARVALID=1 -> ARVALID=0 asynchronously, HREADYOUT=1, state IDLE.
